phy_mgmt_sequencer: RTL and testbench

Owns the eth_mac_axis PHY register port (reg_vld/reg_addr/reg_write/reg_wval/reg_rval/reg_ack).
- After reset, configures the PHY: writes the advertisement register, then enables and restarts auto-negotiation.
- Then periodically polls link status and reports decoded link_up, speed and duplex.
- Arbitrates one host register-access port against the poll engine, so board logic never drives the MAC register port directly.

---
 rtl/phy_mgmt_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_phy_mgmt_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_mgmt_sequencer.sv
// ============================================================================
// Module   : phy_mgmt_sequencer
// Brief    : Configures the PHY after reset, polls link status periodically
//            and arbitrates one host register-access port against the poller
//            on the MAC PHY register port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module phy_mgmt_sequencer #(
    parameter int          POLL_CYCLES = 2500000,
    parameter logic [15:0] ADV_VALUE   = 16'h01E1,
    parameter logic [15:0] CTRL_VALUE  = 16'h1200,
    parameter int          ACK_TIMEOUT = 4095
) (
    input  logic        clk_mac,
    input  logic        rst_n,
    input  logic        cfg_restart,
    input  logic        host_vld,
    input  logic [4:0]  host_addr,
    input  logic        host_write,
    input  logic [15:0] host_wval,
    output logic [15:0] host_rval,
    output logic        host_ack,
    output logic        reg_vld,
    output logic [4:0]  reg_addr,
    output logic        reg_write,
    output logic [15:0] reg_wval,
    input  logic [15:0] reg_rval,
    input  logic        reg_ack,
    output logic        link_up,
    output logic        an_done,
    output logic        speed_100,
    output logic        full_duplex,
    output logic        status_valid,
    output logic        mgmt_err
);

    localparam int PW = $clog2(POLL_CYCLES + 1);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_CFG_ADV   = 3'd0,
        S_CFG_CTRL  = 3'd1,
        S_IDLE      = 3'd2,
        S_POLL_BMSR = 3'd3,
        S_POLL_SCSR = 3'd4,
        S_HOST      = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic           reg_vld_q, reg_vld_d;
    logic [4:0]     reg_addr_q, reg_addr_d;
    logic           reg_write_q, reg_write_d;
    logic [15:0]    reg_wval_q, reg_wval_d;
    logic [15:0]    host_rval_q, host_rval_d;
    logic           host_ack_q, host_ack_d;
    logic           link_up_q, link_up_d;
    logic           an_done_q, an_done_d;
    logic           speed_100_q, speed_100_d;
    logic           full_duplex_q, full_duplex_d;
    logic           status_valid_q, status_valid_d;
    logic           mgmt_err_q, mgmt_err_d;
    logic [PW-1:0]  poll_cnt_q, poll_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           restart_q, restart_d;
    logic           launch;
    logic           timeout;
    logic [15:0]    rval_eff;

    // Next-state, transaction launch/completion and status decode
    always_comb begin
        state_d        = state_q;
        reg_vld_d      = reg_vld_q;
        reg_addr_d     = reg_addr_q;
        reg_write_d    = reg_write_q;
        reg_wval_d     = reg_wval_q;
        host_rval_d    = host_rval_q;
        host_ack_d     = 1'b0;
        link_up_d      = link_up_q;
        an_done_d      = an_done_q;
        speed_100_d    = speed_100_q;
        full_duplex_d  = full_duplex_q;
        status_valid_d = status_valid_q;
        mgmt_err_d     = mgmt_err_q;
        poll_cnt_d     = (poll_cnt_q == POLL_LAST) ? poll_cnt_q : poll_cnt_q + 1'b1;
        to_cnt_d       = to_cnt_q;
        restart_d      = restart_q | cfg_restart;
        launch         = 1'b0;
        timeout        = reg_vld_q && !reg_ack && (to_cnt_q == TO_LAST);
        rval_eff       = reg_ack ? reg_rval : 16'hFFFF;

        case (state_q)
            S_IDLE: begin
                // host_ack_q blocks re-accepting a request the host is
                // still holding during its completion cycle
                if (restart_q) begin
                    state_d   = S_CFG_ADV;
                    restart_d = cfg_restart;
                    launch    = 1'b1;
                end else if (host_vld && !host_ack_q) begin
                    state_d = S_HOST;
                    launch  = 1'b1;
                end else if (poll_cnt_q == POLL_LAST) begin
                    state_d    = S_POLL_BMSR;
                    poll_cnt_d = '0;
                    launch     = 1'b1;
                end
            end
            default: begin
                // A transaction state with reg_vld low is the idle gap
                // cycle after the previous transaction; issue now.
                if (!reg_vld_q) begin
                    launch = 1'b1;
                end else if (reg_ack || timeout) begin
                    reg_vld_d = 1'b0;
                    if (!reg_ack) begin
                        mgmt_err_d = 1'b1;
                    end
                    case (state_q)
                        S_CFG_ADV: state_d = S_CFG_CTRL;
                        S_CFG_CTRL: begin
                            state_d    = S_POLL_BMSR;
                            poll_cnt_d = '0;
                        end
                        S_POLL_BMSR: begin
                            if (reg_ack) begin
                                link_up_d = reg_rval[2];
                                an_done_d = reg_rval[5];
                            end
                            state_d = S_POLL_SCSR;
                        end
                        S_POLL_SCSR: begin
                            if (reg_ack) begin
                                speed_100_d    = (reg_rval[4:2] == 3'b010) ||
                                                 (reg_rval[4:2] == 3'b110);
                                full_duplex_d  = reg_rval[4];
                                status_valid_d = 1'b1;
                            end
                            state_d = S_IDLE;
                        end
                        S_HOST: begin
                            host_ack_d  = 1'b1;
                            host_rval_d = (reg_write_q && reg_ack) ? 16'h0000 : rval_eff;
                            state_d     = S_IDLE;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
        endcase

        if (launch) begin
            reg_vld_d = 1'b1;
            to_cnt_d  = '0;
            case (state_d)
                S_CFG_ADV: begin
                    reg_addr_d = 5'd4;  reg_write_d = 1'b1; reg_wval_d = ADV_VALUE;
                end
                S_CFG_CTRL: begin
                    reg_addr_d = 5'd0;  reg_write_d = 1'b1; reg_wval_d = CTRL_VALUE;
                end
                S_POLL_BMSR: begin
                    reg_addr_d = 5'd1;  reg_write_d = 1'b0; reg_wval_d = 16'h0000;
                end
                S_POLL_SCSR: begin
                    reg_addr_d = 5'd31; reg_write_d = 1'b0; reg_wval_d = 16'h0000;
                end
                S_HOST: begin
                    reg_addr_d  = host_addr;
                    reg_write_d = host_write;
                    reg_wval_d  = host_write ? host_wval : 16'h0000;
                end
                default: reg_vld_d = 1'b0;
            endcase
        end
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk_mac) begin
        if (!rst_n) begin
            state_q        <= S_CFG_ADV;
            reg_vld_q      <= 1'b0;
            reg_addr_q     <= '0;
            reg_write_q    <= 1'b0;
            reg_wval_q     <= '0;
            host_rval_q    <= '0;
            host_ack_q     <= 1'b0;
            link_up_q      <= 1'b0;
            an_done_q      <= 1'b0;
            speed_100_q    <= 1'b0;
            full_duplex_q  <= 1'b0;
            status_valid_q <= 1'b0;
            mgmt_err_q     <= 1'b0;
            poll_cnt_q     <= '0;
            to_cnt_q       <= '0;
            restart_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            reg_vld_q      <= reg_vld_d;
            reg_addr_q     <= reg_addr_d;
            reg_write_q    <= reg_write_d;
            reg_wval_q     <= reg_wval_d;
            host_rval_q    <= host_rval_d;
            host_ack_q     <= host_ack_d;
            link_up_q      <= link_up_d;
            an_done_q      <= an_done_d;
            speed_100_q    <= speed_100_d;
            full_duplex_q  <= full_duplex_d;
            status_valid_q <= status_valid_d;
            mgmt_err_q     <= mgmt_err_d;
            poll_cnt_q     <= poll_cnt_d;
            to_cnt_q       <= to_cnt_d;
            restart_q      <= restart_d;
        end
    end

    assign reg_vld      = reg_vld_q;
    assign reg_addr     = reg_addr_q;
    assign reg_write    = reg_write_q;
    assign reg_wval     = reg_wval_q;
    assign host_rval    = host_rval_q;
    assign host_ack     = host_ack_q;
    assign link_up      = link_up_q;
    assign an_done      = an_done_q;
    assign speed_100    = speed_100_q;
    assign full_duplex  = full_duplex_q;
    assign status_valid = status_valid_q;
    assign mgmt_err     = mgmt_err_q;

endmodule

`default_nettype wire

// File: tb/tb_phy_mgmt_sequencer.sv
// ============================================================================
// Module   : tb_phy_mgmt_sequencer
// Brief    : Directed self-checking bench for phy_mgmt_sequencer with a
//            simple MAC register-port responder and transaction log.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_phy_mgmt_sequencer;

    logic        clk_mac = 1'b0;
    logic        rst_n = 1'b0;
    logic        cfg_restart = 1'b0;
    logic        host_vld = 1'b0;
    logic [4:0]  host_addr = '0;
    logic        host_write = 1'b0;
    logic [15:0] host_wval = '0;
    logic [15:0] host_rval;
    logic        host_ack;
    logic        reg_vld;
    logic [4:0]  reg_addr;
    logic        reg_write;
    logic [15:0] reg_wval;
    logic [15:0] reg_rval = '0;
    logic        reg_ack = 1'b0;
    logic        link_up, an_done, speed_100, full_duplex, status_valid, mgmt_err;

    phy_mgmt_sequencer #(
        .POLL_CYCLES (20),
        .ADV_VALUE   (16'h01E1),
        .CTRL_VALUE  (16'h1200),
        .ACK_TIMEOUT (15)
    ) u_dut (
        .clk_mac      (clk_mac),
        .rst_n        (rst_n),
        .cfg_restart  (cfg_restart),
        .host_vld     (host_vld),
        .host_addr    (host_addr),
        .host_write   (host_write),
        .host_wval    (host_wval),
        .host_rval    (host_rval),
        .host_ack     (host_ack),
        .reg_vld      (reg_vld),
        .reg_addr     (reg_addr),
        .reg_write    (reg_write),
        .reg_wval     (reg_wval),
        .reg_rval     (reg_rval),
        .reg_ack      (reg_ack),
        .link_up      (link_up),
        .an_done      (an_done),
        .speed_100    (speed_100),
        .full_duplex  (full_duplex),
        .status_valid (status_valid),
        .mgmt_err     (mgmt_err)
    );

    always #5 clk_mac = ~clk_mac;

    int errors = 0;
    int checks = 0;

    // MAC responder state and transaction log
    logic [15:0] bmsr_val = 16'h782D;
    logic [15:0] scsr_val = 16'h0058;
    logic        noack    = 1'b0;
    int          mcnt     = 0;
    logic        macked   = 1'b0;
    logic        prev_vld = 1'b0;
    logic [4:0]  la [256];
    logic        lw [256];
    logic [15:0] lv [256];
    int          ldur [256];
    int          log_n = 0;

    // MAC model: logs each request, acks after 4 cycles (12 for reg 2)
    always @(negedge clk_mac) begin
        reg_ack = 1'b0;
        if (reg_vld) begin
            if (!prev_vld && log_n < 256) begin
                la[log_n]   = reg_addr;
                lw[log_n]   = reg_write;
                lv[log_n]   = reg_wval;
                ldur[log_n] = 0;
                log_n       = log_n + 1;
                mcnt        = 0;
                macked      = 1'b0;
            end
            if (log_n > 0) ldur[log_n-1] = ldur[log_n-1] + 1;
            mcnt = mcnt + 1;
            if (!macked && mcnt == ((reg_addr == 5'd2) ? 12 : 4) &&
                !(noack && reg_addr == 5'd1)) begin
                reg_ack = 1'b1;
                macked  = 1'b1;
                case (reg_addr)
                    5'd1:    reg_rval = bmsr_val;
                    5'd31:   reg_rval = scsr_val;
                    5'd2:    reg_rval = 16'h0007;
                    default: reg_rval = 16'h1234;
                endcase
            end
        end
        prev_vld = reg_vld;
    end

    task automatic tick();
        @(posedge clk_mac);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_entry(input logic [4:0] a, input int from, input int budget, output int idx);
        idx = -1;
        for (int c = 0; c < budget && idx < 0; c++) begin
            tick();
            for (int k = from; k < log_n; k++)
                if (idx < 0 && la[k] == a) idx = k;
        end
        check($sformatf("seen_addr%0d", a), 32'(idx >= 0), 32'd1);
        if (idx < 0) idx = from;
    endtask

    task automatic wait_host_ack(input int budget);
        for (int c = 0; c < budget && !host_ack; c++) tick();
        check("host_ack_seen", 32'(host_ack), 32'd1);
    endtask

    initial begin
        int i, j, k, n;
        logic [15:0] rv;

        // 1. Reset state, configuration and first poll order
        repeat (3) tick();
        check("rst_reg_vld", 32'(reg_vld), 0);
        check("rst_host_ack", 32'(host_ack), 0);
        check("rst_link_up", 32'(link_up), 0);
        check("rst_status_valid", 32'(status_valid), 0);
        check("rst_mgmt_err", 32'(mgmt_err), 0);
        rst_n = 1'b1;
        wait_entry(5'd31, 0, 100, i);
        check("seq_idx", 32'(i), 3);
        check("seq0", {10'd0, la[0], lw[0], lv[0]}, {10'd0, 5'd4,  1'b1, 16'h01E1});
        check("seq1", {10'd0, la[1], lw[1], lv[1]}, {10'd0, 5'd0,  1'b1, 16'h1200});
        check("seq2", {10'd0, la[2], lw[2], lv[2]}, {10'd0, 5'd1,  1'b0, 16'h0000});
        check("seq3", {10'd0, la[3], lw[3], lv[3]}, {10'd0, 5'd31, 1'b0, 16'h0000});
        for (int c = 0; c < 30 && !status_valid; c++) tick();

        // 2. Decoded status from 0x782D / 0x0058, then link down 0x7809
        check("p1_status_valid", 32'(status_valid), 1);
        check("p1_link_up", 32'(link_up), 1);
        check("p1_an_done", 32'(an_done), 1);
        check("p1_speed_100", 32'(speed_100), 1);
        check("p1_full_duplex", 32'(full_duplex), 1);
        check("p1_mgmt_err", 32'(mgmt_err), 0);
        bmsr_val = 16'h7809;
        wait_entry(5'd1, log_n, 60, i);
        wait_entry(5'd31, i + 1, 30, j);
        repeat (8) tick();
        check("p2_link_up", 32'(link_up), 0);
        check("p2_an_done", 32'(an_done), 0);
        check("p2_speed_100", 32'(speed_100), 1);

        // 3. Host read during a poll, then a saturated poll right after
        wait_entry(5'd1, log_n, 60, i);
        host_vld = 1'b1; host_addr = 5'd2; host_write = 1'b0;
        wait_host_ack(60);
        rv = host_rval;
        host_vld = 1'b0;
        check("h_rval", 32'(rv), 32'h0007);
        check("h_after_scsr", 32'(la[i+1]), 31);
        check("h_entry", {26'd0, la[i+2], lw[i+2]}, {26'd0, 5'd2, 1'b0});
        tick();
        check("h_ack_one_cycle", 32'(host_ack), 0);
        check("h_poll_vld", 32'(reg_vld), 1);
        check("h_poll_addr", 32'(reg_addr), 1);

        // 4. BMSR read never acked -> timeout after 15 cycles
        noack = 1'b1;
        for (int c = 0; c < 60 && !mgmt_err; c++) tick();
        check("to_mgmt_err", 32'(mgmt_err), 1);
        k = 0;
        for (int m = 0; m < log_n; m++) if (la[m] == 5'd1) k = m;
        check("to_duration", 32'(ldur[k]), 15);
        noack = 1'b0;
        repeat (10) tick();
        check("to_next_scsr", 32'(la[k+1]), 31);
        check("to_link_up", 32'(link_up), 0);
        check("to_an_done", 32'(an_done), 0);
        check("to_err_sticky", 32'(mgmt_err), 1);

        // 5. Restart during a poll with a host write waiting
        bmsr_val = 16'h782D;
        wait_entry(5'd1, log_n, 60, i);
        cfg_restart = 1'b1;
        host_vld = 1'b1; host_addr = 5'd9; host_write = 1'b1; host_wval = 16'hABCD;
        tick();
        cfg_restart = 1'b0;
        wait_host_ack(200);
        rv = host_rval;
        host_vld = 1'b0;
        check("r_host_rval", 32'(rv), 0);
        check("r_seq1", 32'(la[i+1]), 31);
        check("r_seq2", {10'd0, la[i+2], lw[i+2], lv[i+2]}, {10'd0, 5'd4, 1'b1, 16'h01E1});
        check("r_seq3", {10'd0, la[i+3], lw[i+3], lv[i+3]}, {10'd0, 5'd0, 1'b1, 16'h1200});
        check("r_seq4", 32'(la[i+4]), 1);
        check("r_seq5", 32'(la[i+5]), 31);
        check("r_seq6", {10'd0, la[i+6], lw[i+6], lv[i+6]}, {10'd0, 5'd9, 1'b1, 16'hABCD});
        check("r_link_up", 32'(link_up), 1);

        // 6. Reset in the middle of the reg 0 write
        cfg_restart = 1'b1;
        tick();
        cfg_restart = 1'b0;
        wait_entry(5'd0, log_n, 100, i);
        rst_n = 1'b0;
        tick();
        check("mr_reg_vld", 32'(reg_vld), 0);
        check("mr_status", {26'd0, link_up, an_done, speed_100, full_duplex, status_valid, mgmt_err}, 0);
        repeat (2) tick();
        n = log_n;
        rst_n = 1'b1;
        wait_entry(5'd4, n, 20, j);
        check("mr_first_idx", 32'(j), 32'(n));
        check("mr_first", {10'd0, la[j], lw[j], lv[j]}, {10'd0, 5'd4, 1'b1, 16'h01E1});
        wait_entry(5'd0, n, 30, k);
        check("mr_second_idx", 32'(k), 32'(n + 1));
        check("mr_second_wval", 32'(lv[k]), 32'h1200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
